// File: rtl/frame_rom_arbiter.sv
// Shares one synchronous frame memory between VGA scanout and a game-logic probe port.
// Display has fixed priority; responses come back through a 3-stage pipeline with palette lookup.
module frame_rom_arbiter #(
    parameter int HORIZONTAL   = 320,
    parameter int VERTICAL     = 240,
    parameter int PIXEL_BITS   = 3,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_disp_req,
    input  logic [9:0]            i_disp_x,
    input  logic [8:0]            i_disp_y,
    output logic                  o_disp_valid,
    output logic [23:0]           o_disp_rgb,
    input  logic                  i_probe_valid,
    output logic                  o_probe_ready,
    input  logic [9:0]            i_probe_x,
    input  logic [8:0]            i_probe_y,
    output logic                  o_probe_rvalid,
    output logic [PIXEL_BITS-1:0] o_probe_label,
    output logic [23:0]           o_probe_rgb,
    output logic                  o_probe_starved,
    input  logic                  i_pal_we,
    input  logic [PIXEL_BITS-1:0] i_pal_idx,
    input  logic [23:0]           i_pal_data,
    output logic [16:0]           o_mem_addr,
    input  logic [PIXEL_BITS-1:0] i_mem_label
);
    localparam int         NPAL  = 1 << PIXEL_BITS;
    localparam int         SCW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [9:0] X_LIM = 10'(2 * HORIZONTAL);
    localparam logic [8:0] Y_LIM = 9'(2 * VERTICAL);

    logic                  probe_acc, req_v, req_disp, req_oor;
    logic [9:0]            sel_x;
    logic [8:0]            sel_y;
    logic [16:0]           addr_d;
    logic [2:1]            vld_q, disp_q, oor_q;
    logic [16:0]           mem_addr_q;
    logic                  disp_valid_q, probe_rvalid_q;
    logic [23:0]           disp_rgb_q, probe_rgb_q;
    logic [PIXEL_BITS-1:0] probe_label_q;
    logic [NPAL-1:0][23:0] pal_q;
    logic [SCW-1:0]        starve_q, starve_d;
    logic [PIXEL_BITS-1:0] s3_label;
    logic [23:0]           s3_rgb;

    // Stage 0: display always wins the slot; the stored frame is 2x upscaled.
    assign o_probe_ready = !i_disp_req;
    assign probe_acc     = i_probe_valid && o_probe_ready;
    assign req_v         = i_disp_req || probe_acc;
    assign req_disp      = i_disp_req;
    assign sel_x         = i_disp_req ? i_disp_x : i_probe_x;
    assign sel_y         = i_disp_req ? i_disp_y : i_probe_y;
    assign req_oor       = (sel_x >= X_LIM) || (sel_y >= Y_LIM);
    assign addr_d        = 17'(sel_y[8:1]) * 17'(HORIZONTAL) + 17'(sel_x[9:1]);

    // Out-of-range requests keep their slot but are forced to black label 0.
    assign s3_label = oor_q[2] ? '0 : i_mem_label;
    assign s3_rgb   = oor_q[2] ? '0 : pal_q[i_mem_label];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q          <= '0;
            disp_q         <= '0;
            oor_q          <= '0;
            mem_addr_q     <= '0;
            disp_valid_q   <= 1'b0;
            probe_rvalid_q <= 1'b0;
            disp_rgb_q     <= '0;
            probe_rgb_q    <= '0;
            probe_label_q  <= '0;
        end else begin
            vld_q          <= {vld_q[1], req_v};
            disp_q         <= {disp_q[1], req_disp};
            oor_q          <= {oor_q[1], req_oor};
            if (req_v)
                mem_addr_q <= req_oor ? '0 : addr_d;
            disp_valid_q   <= vld_q[2] && disp_q[2];
            probe_rvalid_q <= vld_q[2] && !disp_q[2];
            if (vld_q[2] && disp_q[2])
                disp_rgb_q <= s3_rgb;
            if (vld_q[2] && !disp_q[2]) begin
                probe_label_q <= s3_label;
                probe_rgb_q   <= s3_rgb;
            end
        end
    end

    // Palette reads in the write cycle see the old entry; reset restores a grey ramp.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NPAL; k++)
                pal_q[k] <= {3{8'(k * 36)}};
        end else if (i_pal_we) begin
            pal_q[i_pal_idx] <= i_pal_data;
        end
    end

    always_comb begin
        starve_d = '0;
        if (i_probe_valid && !o_probe_ready)
            starve_d = (starve_q == SCW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end

    assign o_probe_starved = (starve_q == SCW'(STARVE_LIMIT));
    assign o_mem_addr      = mem_addr_q;
    assign o_disp_valid    = disp_valid_q;
    assign o_disp_rgb      = disp_rgb_q;
    assign o_probe_rvalid  = probe_rvalid_q;
    assign o_probe_label   = probe_label_q;
    assign o_probe_rgb     = probe_rgb_q;
endmodule

// File: tb/tb_frame_rom_arbiter.sv
// Randomized bench for frame_rom_arbiter: a response queue with due cycles, a palette array
// and a stall counter predict every strobe, colour, label, address and starvation flag.
module tb_frame_rom_arbiter;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        d_req = 1'b0, p_val = 1'b0, pw_we = 1'b0;
    logic [9:0]  d_x = '0, p_x = '0;
    logic [8:0]  d_y = '0, p_y = '0;
    logic [2:0]  pw_idx = '0;
    logic [23:0] pw_data = '0;
    logic [2:0]  i_mem_label = '0;
    logic        o_disp_valid, o_probe_ready, o_probe_rvalid, o_probe_starved;
    logic [23:0] o_disp_rgb, o_probe_rgb;
    logic [2:0]  o_probe_label;
    logic [16:0] o_mem_addr;

    frame_rom_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_disp_req(d_req), .i_disp_x(d_x), .i_disp_y(d_y),
        .o_disp_valid(o_disp_valid), .o_disp_rgb(o_disp_rgb),
        .i_probe_valid(p_val), .o_probe_ready(o_probe_ready),
        .i_probe_x(p_x), .i_probe_y(p_y),
        .o_probe_rvalid(o_probe_rvalid), .o_probe_label(o_probe_label),
        .o_probe_rgb(o_probe_rgb), .o_probe_starved(o_probe_starved),
        .i_pal_we(pw_we), .i_pal_idx(pw_idx), .i_pal_data(pw_data),
        .o_mem_addr(o_mem_addr), .i_mem_label(i_mem_label)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous single-port frame memory: data one cycle after the address.
    bit [2:0] mem [0:76799];
    always @(posedge i_clk) i_mem_label <= mem[o_mem_addr];

    typedef struct {
        bit        disp;
        int        due;
        bit [2:0]  lbl;
        bit [23:0] rgb;
        bit        oor;
    } exp_t;

    exp_t      q[$];
    bit [23:0] pal_m [8];
    bit [23:0] last_drgb, last_prgb;
    bit [2:0]  last_plbl;
    int        stall, cyc, n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit [23:0] ramp(input int k);
        bit [7:0] g;
        g = 8'(k * 36);
        return {g, g, g};
    endfunction

    task automatic reset_model();
        q.delete();
        for (int k = 0; k < 8; k++) pal_m[k] = ramp(k);
        last_drgb = '0; last_prgb = '0; last_plbl = '0; stall = 0;
    endtask

    // One clock: entered just after a negedge with inputs applied, leaves at the next negedge.
    task automatic step();
        bit   acc, oor, dv, pv;
        int   ax, ay, addr;
        exp_t e;
        #1;
        chk("ready", 32'(o_probe_ready), 32'(!d_req));
        acc  = d_req || p_val;
        addr = 0;
        if (acc) begin
            ax   = d_req ? int'(d_x) : int'(p_x);
            ay   = d_req ? int'(d_y) : int'(p_y);
            oor  = (ax >= 640) || (ay >= 480);
            addr = oor ? 0 : (ay / 2) * 320 + ax / 2;
            e.disp = d_req; e.due = cyc + 3; e.oor = oor;
            e.lbl  = oor ? 3'd0 : mem[addr];
            e.rgb  = '0;
            q.push_back(e);
        end
        // Colour is fixed by the palette as it stands the cycle before the response.
        foreach (q[i])
            if (q[i].due == cyc + 1) q[i].rgb = q[i].oor ? 24'h0 : pal_m[q[i].lbl];
        if (p_val && d_req) stall = (stall < 64) ? stall + 1 : 64;
        else                stall = 0;
        if (pw_we) pal_m[pw_idx] = pw_data;
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
        dv = 0; pv = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.disp) begin dv = 1; last_drgb = e.rgb; end
            else begin pv = 1; last_plbl = e.lbl; last_prgb = e.rgb; end
        end
        chk("disp_valid", 32'(o_disp_valid), 32'(dv));
        chk("probe_rvalid", 32'(o_probe_rvalid), 32'(pv));
        chk("disp_rgb", 32'(o_disp_rgb), 32'(last_drgb));
        chk("probe_label", 32'(o_probe_label), 32'(last_plbl));
        chk("probe_rgb", 32'(o_probe_rgb), 32'(last_prgb));
        chk("starved", 32'(o_probe_starved), 32'(stall == 64));
        if (acc) chk("mem_addr", 32'(o_mem_addr), 32'(addr));
    endtask

    task automatic idle();
        d_req = 0; p_val = 0; pw_we = 0;
    endtask

    task automatic disp(input int x, input int y);
        idle(); d_req = 1; d_x = 10'(x); d_y = 9'(y);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dv"}, 32'(o_disp_valid), 0);
        chk({tag, "_drgb"}, 32'(o_disp_rgb), 0);
        chk({tag, "_pv"}, 32'(o_probe_rvalid), 0);
        chk({tag, "_plbl"}, 32'(o_probe_label), 0);
        chk({tag, "_prgb"}, 32'(o_probe_rgb), 0);
        chk({tag, "_starved"}, 32'(o_probe_starved), 0);
        chk({tag, "_addr"}, 32'(o_mem_addr), 0);
    endtask

    initial begin
        for (int a = 0; a < 76800; a++) mem[a] = 3'($urandom);
        mem[965] = 3'd5; mem[76799] = 3'd7; mem[0] = 3'd3; mem[100] = 3'd2; mem[101] = 3'd2;
        reset_model();
        cyc = 0; n_chk = 0; n_pass = 0;
        repeat (2) @(negedge i_clk);
        chk_all_zero("reset");
        i_rst_n = 1;

        // Display pixel (10,6) -> address 965, label 5 -> 0xB4B4B4.
        disp(10, 6); step();
        chk("t1_addr", 32'(o_mem_addr), 965);
        idle(); step(); step();
        chk("t1_dv", 32'(o_disp_valid), 1);
        chk("t1_rgb", 32'(o_disp_rgb), 32'h00B4B4B4);

        // Probe at the last pixel while display idle.
        idle(); p_val = 1; p_x = 10'd639; p_y = 9'd479; step();
        chk("t2_addr", 32'(o_mem_addr), 76799);
        idle(); step(); step();
        chk("t2_pv", 32'(o_probe_rvalid), 1);
        chk("t2_lbl", 32'(o_probe_label), 7);
        chk("t2_rgb", 32'(o_probe_rgb), 32'h00FCFCFC);

        // Starvation: probe held behind display for 70 cycles.
        for (int i = 0; i < 70; i++) begin
            disp($urandom_range(639), $urandom_range(479));
            p_val = 1; p_x = 10'($urandom_range(639)); p_y = 9'($urandom_range(479));
            step();
            if (i == 62) chk("t3_not_yet", 32'(o_probe_starved), 0);
            if (i == 63) chk("t3_starved", 32'(o_probe_starved), 1);
        end
        chk("t3_hold", 32'(o_probe_starved), 1);
        d_req = 0; step();
        chk("t3_clear", 32'(o_probe_starved), 0);

        // Alternating display / probe every cycle.
        for (int i = 0; i < 20; i++) begin
            disp($urandom_range(639), $urandom_range(479));
            d_req = i[0];
            p_val = 1; p_x = 10'($urandom_range(639)); p_y = 9'($urandom_range(479));
            step();
        end
        idle(); repeat (4) step();

        // Palette write racing a label-2 lookup: old colour, then new colour.
        disp(200, 0); step();
        idle(); step();
        pw_we = 1; pw_idx = 3'd2; pw_data = 24'h123456; step();
        chk("t5_old", 32'(o_disp_rgb), 32'h00484848);
        disp(202, 0); step();
        idle(); step(); step();
        chk("t5_new", 32'(o_disp_rgb), 32'h00123456);

        // Out-of-range display.
        disp(640, 0); step();
        chk("t6_addr", 32'(o_mem_addr), 0);
        idle(); step(); step();
        chk("t6_dv", 32'(o_disp_valid), 1);
        chk("t6_rgb", 32'(o_disp_rgb), 0);

        // Reset with three requests in flight.
        disp(10, 6); step();
        disp(200, 0); step();
        disp(20, 30); step();
        idle();
        i_rst_n = 0;
        reset_model();
        #1 chk_all_zero("midrst");
        repeat (3) step();
        i_rst_n = 1;
        disp(202, 0); step();
        idle(); step(); step();
        chk("t7_pal", 32'(o_disp_rgb), 32'h00484848);

        // Random traffic, including out-of-range coordinates and palette writes.
        for (int i = 0; i < 400; i++) begin
            d_req   = ($urandom_range(99) < 45);
            d_x     = 10'($urandom_range(700)); d_y = 9'($urandom_range(510));
            p_val   = ($urandom_range(99) < 60);
            p_x     = 10'($urandom_range(700)); p_y = 9'($urandom_range(510));
            pw_we   = ($urandom_range(7) == 0);
            pw_idx  = 3'($urandom);
            pw_data = 24'($urandom);
            step();
        end
        idle(); repeat (4) step();
        chk("drain", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_rom_arbiter.md
Name: frame_rom_arbiter

Overview:
- Shares one single-port, synchronous palettized frame memory (320x240 labels, 3-bit each) between two readers: the VGA scanout (display) and a game-logic probe port (collision and hit tests).
- Generates the 2x-upscaled memory address, arbitrates with fixed display priority, and owns the writable 8-entry label-to-RGB palette.
- Sits between the VGA timing generator and the frame memory. Game logic reprograms the palette at run time.

Parameters:
- HORIZONTAL, 320, stored frame width in labels.
- VERTICAL, 240, stored frame height in labels.
- PIXEL_BITS, 3, label width; the palette has 1<<PIXEL_BITS entries.
- STARVE_LIMIT, 64, consecutive stalled probe cycles before o_probe_starved asserts.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_disp_req  in  1  display pixel request, one cycle per pixel.
- i_disp_x  in  10  display x, 0..639.
- i_disp_y  in  9  display y, 0..479.
- o_disp_valid  out  1  display response strobe.
- o_disp_rgb  out  24  display colour.
- i_probe_valid  in  1  probe request valid.
- o_probe_ready  out  1  probe request accepted this cycle.
- i_probe_x  in  10  probe x.
- i_probe_y  in  9  probe y.
- o_probe_rvalid  out  1  probe response strobe; no backpressure.
- o_probe_label  out  3  probe label.
- o_probe_rgb  out  24  probe colour.
- o_probe_starved  out  1  probe stalled STARVE_LIMIT cycles.
- i_pal_we  in  1  palette write enable.
- i_pal_idx  in  3  palette entry.
- i_pal_data  in  24  palette write data.
- o_mem_addr  out  17  frame memory address, registered.
- i_mem_label  in  3  frame memory data, valid one cycle after o_mem_addr.

Behaviour:
- Arbitration:
  - o_probe_ready = !i_disp_req (combinational).
  - A probe is accepted when i_probe_valid && o_probe_ready.
  - Display is never delayed.
  - At most one request is issued per cycle.
- Address:
  - addr = i_y[8:1]*HORIZONTAL + i_x[9:1], computed at 17 bits.
  - Registered into o_mem_addr in the cycle after acceptance (stage 1).
- Out of range (x>=640 or y>=480):
  - The request still occupies its slot.
  - o_mem_addr is driven to 0.
  - The response is forced to label 0 and rgb 24'h000000, regardless of palette contents.
- Pipeline:
  - Stage 0: accept.
  - Stage 1: o_mem_addr registered; a tag (display/probe) and an out-of-range flag travel alongside.
  - Stage 2: i_mem_label is sampled.
  - Stage 3: palette lookup is registered and the response strobe issues.
  - Fixed latency: a request accepted in cycle N responds in cycle N+3 (o_disp_valid or o_probe_rvalid), high for exactly one cycle.
  - Throughput is one request per cycle. The two response strobes are never high in the same cycle.
- o_probe_label and o_probe_rgb:
  - Updated only on o_probe_rvalid; otherwise they hold.
  - o_disp_rgb behaves the same way on o_disp_valid.
- Palette:
  - 8 x 24-bit registers.
  - A write on i_pal_we takes effect the next cycle.
  - A stage-3 lookup of the same index in the write cycle returns the old value.
  - Reset value of entry k is {3{k*8'd36}} (grey ramp 0x000000 .. 0xFCFCFC).
- Starvation counter:
  - Increments each cycle i_probe_valid && !o_probe_ready, saturating at STARVE_LIMIT.
  - Clears on acceptance or when i_probe_valid is low.
  - o_probe_starved = (count == STARVE_LIMIT).
- Reset (asynchronous, any time, including mid-pipeline):
  - All stage valids clear and in-flight responses are dropped.
  - Outputs go to 0: o_disp_valid, o_disp_rgb, o_probe_rvalid, o_probe_label, o_probe_rgb, o_probe_starved, o_mem_addr.
  - The palette returns to its ramp values.
  - First response after release comes no earlier than 3 cycles after the first accepted request.

Test Plan:
- Reset, then display request (x=10,y=6) in cycle N with memory model returning label 5 at addr 965 -> o_mem_addr=965 at N+1; o_disp_valid=1 and o_disp_rgb=24'hB4B4B4 at N+3.
- Probe (x=639,y=479) while i_disp_req=0, memory label 7 -> o_probe_ready=1; o_mem_addr=76799; at N+3 o_probe_rvalid=1, o_probe_label=7, o_probe_rgb=24'hFCFCFC.
- Probe held valid with i_disp_req high for 70 cycles -> o_probe_ready=0 throughout; o_probe_starved rises on stall cycle 64 and holds. Drop i_disp_req -> probe accepted, starved clears next cycle.
- Alternating display and probe requests every cycle for 20 cycles -> responses return in issue order at +3, strobes never overlap, labels match the memory model.
- Write palette idx 2 = 24'h123456 in the same cycle a label-2 display response is in stage 3 -> that response shows 24'h484848; the next label-2 response shows 24'h123456.
- Display (x=640,y=0) -> o_mem_addr=0, o_disp_rgb=0 at +3. Assert i_rst_n=0 with 3 requests in flight -> no response strobes; all outputs 0 and palette restored.
